// File: rtl/matrix_spi_receiver_if.sv
// Serial-line and report bundle for matrix_spi_receiver.
// The transmitter side drives the SPI/shift-register lines; the receiver produces word/column reports.
interface matrix_spi_receiver_if #(
    parameter int CHANNEL_NUMBER   = 3,
    parameter int SPI_SIZE         = 8,
    parameter int COLUMN_COUNT     = 16,
    parameter int WORDS_PER_COLUMN = 24
);
    logic                                 spi_clk;
    logic [CHANNEL_NUMBER-1:0]            spi_mosi;
    logic                                 ser_clk;
    logic                                 ser_data;
    logic                                 ser_stcp;
    logic                                 ser_n_enable;

    logic                                 word_valid;
    logic [CHANNEL_NUMBER*SPI_SIZE-1:0]   word_data;
    logic [$clog2(WORDS_PER_COLUMN+1)-1:0] word_index;
    logic [$clog2(COLUMN_COUNT)-1:0]      column_index;
    logic                                 column_valid;
    logic                                 column_strobe;
    logic                                 frame_error;
    logic [15:0]                          err_count;

    modport slave (
        input  spi_clk, spi_mosi, ser_clk, ser_data, ser_stcp, ser_n_enable,
        output word_valid, word_data, word_index, column_index, column_valid,
               column_strobe, frame_error, err_count
    );

    modport master (
        output spi_clk, spi_mosi, ser_clk, ser_data, ser_stcp, ser_n_enable,
        input  word_valid, word_data, word_index, column_index, column_valid,
               column_strobe, frame_error, err_count
    );
endinterface

// File: rtl/matrix_spi_receiver.sv
// Oversampling receiver for the matrix SPI words and column shift-register latch.
// Optional feature: define RX_ERROR_COUNT_EN to build the saturating framing-fault counter.
module matrix_spi_receiver #(
    parameter int CHANNEL_NUMBER   = 3,
    parameter int SPI_SIZE         = 8,
    parameter int MSB_FIRST        = 1,
    parameter int COLUMN_COUNT     = 16,
    parameter int WORDS_PER_COLUMN = 24,
    parameter int IDLE_TIMEOUT     = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    matrix_spi_receiver_if.slave  bus
);
    localparam int BIT_W  = $clog2(SPI_SIZE + 1);
    localparam int IDX_W  = $clog2(WORDS_PER_COLUMN + 1);
    localparam int COL_W  = $clog2(COLUMN_COUNT);
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [COLUMN_COUNT-1:0] COL_ONE = {{(COLUMN_COUNT-1){1'b0}}, 1'b1};

    // Control line order: 0 spi_clk, 1 ser_clk, 2 ser_data, 3 ser_stcp, 4 ser_n_enable
    logic [4:0]                ctl_raw, ctl_s1, ctl_s2, ctl_s3;
    logic [CHANNEL_NUMBER-1:0] mosi_s1, mosi_s2, mosi_s3;

    logic ev_spi_rise, ev_spi_edge, ev_ser_rise, ev_stcp_rise;
    logic stcp_q, timeout_hit;

    logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0] shifter;
    logic [BIT_W-1:0]          bit_cnt;
    logic [IDX_W-1:0]          word_cnt;
    logic [IDLE_W-1:0]         idle_cnt;
    logic [COLUMN_COUNT-1:0]   shift_reg, latch_reg;

    logic                                word_valid_q, column_strobe_q, frame_error_q, column_valid_q;
    logic [CHANNEL_NUMBER*SPI_SIZE-1:0]  word_data_q;
    logic [IDX_W-1:0]                    word_index_q;
    logic [COL_W-1:0]                    column_index_q, low_idx;

    logic word_done, overflow, partial_stcp, partial_timeout, fault, onehot;

    assign ctl_raw = {bus.ser_n_enable, bus.ser_stcp, bus.ser_data, bus.ser_clk, bus.spi_clk};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_s1  <= '0;
            ctl_s2  <= '0;
            ctl_s3  <= '0;
            mosi_s1 <= '0;
            mosi_s2 <= '0;
            mosi_s3 <= '0;
        end else begin
            ctl_s1  <= ctl_raw;
            ctl_s2  <= ctl_s1;
            ctl_s3  <= ctl_s2;
            mosi_s1 <= bus.spi_mosi;
            mosi_s2 <= mosi_s1;
            mosi_s3 <= mosi_s2;
        end
    end

    // Edge events are registered so that shifting happens on aligned mosi_s3/ctl_s3 data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_spi_rise  <= 1'b0;
            ev_spi_edge  <= 1'b0;
            ev_ser_rise  <= 1'b0;
            ev_stcp_rise <= 1'b0;
        end else begin
            ev_spi_rise  <= ctl_s2[0] & ~ctl_s3[0];
            ev_spi_edge  <= ctl_s2[0] ^ ctl_s3[0];
            ev_ser_rise  <= ctl_s2[1] & ~ctl_s3[1];
            ev_stcp_rise <= ctl_s2[3] & ~ctl_s3[3];
        end
    end

    assign word_done       = (bit_cnt == BIT_W'(SPI_SIZE));
    assign overflow        = word_done && (word_cnt >= IDX_W'(WORDS_PER_COLUMN));
    assign partial_stcp    = stcp_q && (bit_cnt != '0) && !word_done;
    assign partial_timeout = timeout_hit && (bit_cnt != '0) && !word_done;
    assign fault           = overflow | partial_stcp | partial_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shifter <= '0;
        end else if (ev_spi_rise) begin
            for (int c = 0; c < CHANNEL_NUMBER; c++) begin
                if (MSB_FIRST != 0)
                    shifter[c] <= {shifter[c][SPI_SIZE-2:0], mosi_s3[c]};
                else
                    shifter[c] <= {mosi_s3[c], shifter[c][SPI_SIZE-1:1]};
            end
        end
    end

    // Completion, stcp and timeout clears take priority; a new rise cannot land in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (word_done || stcp_q || timeout_hit) begin
            bit_cnt <= '0;
        end else if (ev_spi_rise) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt    <= '0;
            timeout_hit <= 1'b0;
        end else if (ev_spi_edge) begin
            idle_cnt    <= '0;
            timeout_hit <= 1'b0;
        end else if (idle_cnt != IDLE_W'(IDLE_TIMEOUT)) begin
            idle_cnt    <= idle_cnt + IDLE_W'(1);
            timeout_hit <= (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1));
        end else begin
            timeout_hit <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt     <= '0;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
            word_index_q <= '0;
            frame_error_q <= 1'b0;
        end else begin
            word_valid_q  <= 1'b0;
            frame_error_q <= fault;
            if (word_done && !overflow) begin
                word_data_q  <= shifter;
                word_index_q <= word_cnt;
                word_valid_q <= 1'b1;
            end
            if (stcp_q)
                word_cnt <= '0;
            else if (word_done && !overflow)
                word_cnt <= word_cnt + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg       <= '0;
            latch_reg       <= '0;
            stcp_q          <= 1'b0;
            column_strobe_q <= 1'b0;
            column_index_q  <= '0;
            column_valid_q  <= 1'b0;
        end else begin
            if (ev_ser_rise)
                shift_reg <= {shift_reg[COLUMN_COUNT-2:0], ctl_s3[2]};
            if (ev_stcp_rise)
                latch_reg <= shift_reg;
            stcp_q          <= ev_stcp_rise;
            column_strobe_q <= stcp_q;
            column_index_q  <= low_idx;
            column_valid_q  <= onehot && !ctl_s3[4];
        end
    end

    // Scan from the top so the last assignment wins with the lowest set bit
    always_comb begin
        low_idx = '0;
        for (int i = COLUMN_COUNT - 1; i >= 0; i--) begin
            if (latch_reg[i])
                low_idx = COL_W'(i);
        end
    end

    assign onehot = (latch_reg != '0) && ((latch_reg & (latch_reg - COL_ONE)) == '0);

`ifdef RX_ERROR_COUNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt_q <= '0;
        else if (fault && err_cnt_q != 16'hFFFF)
            err_cnt_q <= err_cnt_q + 16'd1;
    end

    assign bus.err_count = err_cnt_q;
`else
    assign bus.err_count = 16'h0000;
`endif

    assign bus.word_valid    = word_valid_q;
    assign bus.word_data     = word_data_q;
    assign bus.word_index    = word_index_q;
    assign bus.column_index  = column_index_q;
    assign bus.column_valid  = column_valid_q;
    assign bus.column_strobe = column_strobe_q;
    assign bus.frame_error   = frame_error_q;
endmodule

// File: tb/tb_matrix_spi_receiver.sv
// Scoreboard bench for matrix_spi_receiver: directed words/columns, monitor pops expected words.
module tb_matrix_spi_receiver;
    localparam int CN = 3;
    localparam int SZ = 8;
    localparam int IDLE = 1024;
`ifdef RX_ERROR_COUNT_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    typedef struct {
        logic [CN*SZ-1:0] data;
        int               idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   fe_seen = 0;
    int   strobe_seen = 0;
    int   last_rise_cyc = 0;
    int   last_word_cyc = 0;
    int   stcp_cyc = 0;
    int   last_strobe_cyc = 0;
    int   fe_base;

    matrix_spi_receiver_if #(.CHANNEL_NUMBER(CN), .SPI_SIZE(SZ),
                             .COLUMN_COUNT(16), .WORDS_PER_COLUMN(24)) bus ();

    matrix_spi_receiver #(
        .CHANNEL_NUMBER(CN), .SPI_SIZE(SZ), .MSB_FIRST(1), .COLUMN_COUNT(16),
        .WORDS_PER_COLUMN(24), .IDLE_TIMEOUT(IDLE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every reported word is matched against the oldest expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.word_valid) begin
                last_word_cyc = cyc;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word: got data 0x%0h index %0d, expected none",
                             bus.word_data, bus.word_index);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("word_data", bus.word_data, e.data);
                    checkOutput("word_index", bus.word_index, e.idx);
                end
            end
            if (bus.frame_error) fe_seen++;
            if (bus.column_strobe) begin
                strobe_seen++;
                last_strobe_cyc = cyc;
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends the first nbits of each channel's byte, MSB first
    task automatic applyStimulus(input logic [CN*SZ-1:0] word, input int nbits,
                                 input bit expect_word, input int exp_idx);
        exp_t e;
        if (expect_word) begin
            e.data = word;
            e.idx  = exp_idx;
            sb.push_back(e);
        end
        for (int j = 0; j < nbits; j++) begin
            for (int c = 0; c < CN; c++)
                bus.spi_mosi[c] = word[c*SZ + SZ - 1 - j];
            wait_clk(3);
            bus.spi_clk = 1'b1;
            last_rise_cyc = cyc;
            wait_clk(3);
            bus.spi_clk = 1'b0;
            wait_clk(3);
        end
    endtask

    task automatic shift_column(input logic [15:0] pat);
        for (int i = 15; i >= 0; i--) begin
            bus.ser_data = pat[i];
            wait_clk(3);
            bus.ser_clk = 1'b1;
            wait_clk(3);
            bus.ser_clk = 1'b0;
        end
    endtask

    task automatic pulse_stcp();
        bus.ser_stcp = 1'b1;
        stcp_cyc = cyc;
        wait_clk(3);
        bus.ser_stcp = 1'b0;
        wait_clk(6);
    endtask

    function automatic logic [CN*SZ-1:0] make_word(input int i, input int col);
        return {8'(i + col * 40), 8'(~i), 8'(i * 7 + 3)};
    endfunction

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_word_valid"}, bus.word_valid, 0);
        checkOutput({tag, "_word_data"}, bus.word_data, 0);
        checkOutput({tag, "_word_index"}, bus.word_index, 0);
        checkOutput({tag, "_column_index"}, bus.column_index, 0);
        checkOutput({tag, "_column_valid"}, bus.column_valid, 0);
        checkOutput({tag, "_column_strobe"}, bus.column_strobe, 0);
        checkOutput({tag, "_frame_error"}, bus.frame_error, 0);
        checkOutput({tag, "_err_count"}, bus.err_count, 0);
    endtask

    initial begin
        bus.spi_clk = 1'b0;
        bus.spi_mosi = '0;
        bus.ser_clk = 1'b0;
        bus.ser_data = 1'b0;
        bus.ser_stcp = 1'b0;
        bus.ser_n_enable = 1'b1;
        wait_clk(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_clk(3);

        $display("[TB] single word A5/3C/FF");
        applyStimulus(24'hFF3CA5, 8, 1'b1, 0);
        checkOutput("word_latency", last_word_cyc - last_rise_cyc, 5);

        $display("[TB] column latch");
        shift_column(16'h0008);
        bus.ser_n_enable = 1'b0;
        pulse_stcp();
        checkOutput("strobe_count", strobe_seen, 1);
        checkOutput("strobe_latency", last_strobe_cyc - stcp_cyc, 5);
        checkOutput("column_index_3", bus.column_index, 3);
        checkOutput("column_valid_onehot", bus.column_valid, 1);
        shift_column(16'h0009);
        pulse_stcp();
        checkOutput("column_index_0", bus.column_index, 0);
        checkOutput("column_valid_not_onehot", bus.column_valid, 0);

        $display("[TB] word index and overflow");
        fe_base = fe_seen;
        for (int i = 0; i < 24; i++) applyStimulus(make_word(i, 0), 8, 1'b1, i);
        pulse_stcp();
        for (int i = 0; i < 25; i++) applyStimulus(make_word(i, 1), 8, i < 24, i);
        wait_clk(4);
        checkOutput("overflow_frame_error", fe_seen - fe_base, 1);
        checkOutput("overflow_err_count", bus.err_count, ERR_EN);

        $display("[TB] idle timeout");
        pulse_stcp();
        applyStimulus(24'h123456, 8, 1'b1, 0);
        fe_base = fe_seen;
        applyStimulus(24'hF0F0F0, 5, 1'b0, 0);
        wait_clk(2 * IDLE + 50);
        checkOutput("idle_frame_error", fe_seen - fe_base, 1);
        applyStimulus(24'h5AC3E7, 8, 1'b1, 1);

        $display("[TB] stcp mid-word");
        fe_base = fe_seen;
        applyStimulus(24'hAAAAAA, 3, 1'b0, 0);
        pulse_stcp();
        checkOutput("stcp_frame_error", fe_seen - fe_base, 1);
        checkOutput("stcp_err_count", bus.err_count, 3 * ERR_EN);
        applyStimulus(24'h0F1E2D, 8, 1'b1, 0);

        $display("[TB] reset mid-word");
        applyStimulus(24'hCCCCCC, 4, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);
        applyStimulus(24'h818181, 8, 1'b1, 0);

        for (int t = 0; t < 50 && sb.size() != 0; t++) wait_clk(1);
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/matrix_spi_receiver.md
# matrix_spi_receiver

Receive-side counterpart of the FPGA matrix output path. The block oversamples the SPI lines (spi_clk plus one MOSI per channel) and the column shift-register lines (ser_clk/ser_data/ser_stcp/ser_n_enable) on the system clock. It deserializes SPI_SIZE-bit words per channel and reconstructs the latched column select. Each word is reported with its column and word index. It is used as a loopback checker on the Nano9K and as a behavioural stand-in for a CH32V003 matrix module.

## Interface
- CHANNEL_NUMBER, 3, parallel MOSI channels
- SPI_SIZE, 8, bits per word
- MSB_FIRST, 1, 1 = first received bit lands in word MSB; 0 = LSB
- COLUMN_COUNT, 16, shift-register length (column lines)
- WORDS_PER_COLUMN, 24, words expected between consecutive ser_stcp latches
- IDLE_TIMEOUT, 1024, clk cycles of spi_clk inactivity that abort a partial word
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset asynchronous and active-low
- spi_clk  in  1  SPI clock from transmitter (asynchronous to clk)
- spi_mosi  in  CHANNEL_NUMBER  serial data, one bit per channel
- ser_clk, ser_data, ser_stcp, ser_n_enable  in  1 each  column shift-register shift clock, data, storage latch, active-low output enable
- word_valid  out  1  one-cycle pulse: word_data/word_index valid
- word_data  out  CHANNEL_NUMBER*SPI_SIZE  channel i at [i*SPI_SIZE +: SPI_SIZE]
- word_index  out  $clog2(WORDS_PER_COLUMN+1)  index of word within current column
- column_index  out  $clog2(COLUMN_COUNT)  position of set bit in latched column register
- column_valid  out  1  latched register is one-hot and ser_n_enable low
- column_strobe  out  1  one-cycle pulse on each ser_stcp latch
- frame_error  out  1  one-cycle pulse on any framing fault
- err_count  out  16  saturating fault count (see Configuration)

## Operation
- All six inputs pass through 2-FF synchronizers, then a third register for edge detect. MOSI is delayed identically to spi_clk.
- spi_clk rising (sync): shift synchronized MOSI of every channel into its shifter; bit_cnt++. The idle counter clears on either spi_clk edge.
- bit_cnt reaching SPI_SIZE: bit_cnt←0.
  - If word_cnt < WORDS_PER_COLUMN: register word_data, word_index←word_cnt, pulse word_valid, word_cnt++.
  - Otherwise: overflow. Discard the word, pulse frame_error, word_cnt holds.
- ser_clk rising: shift_reg ← {shift_reg[COLUMN_COUNT-2:0], ser_data}.
- ser_stcp rising: latch_reg←shift_reg; pulse column_strobe; word_cnt←0. If bit_cnt≠0, pulse frame_error and set bit_cnt←0.
- column_index = lowest set bit of latch_reg, or 0 if none. column_valid = latch_reg one-hot AND synchronized ser_n_enable==0.
- Idle counter reaching IDLE_TIMEOUT with bit_cnt≠0: bit_cnt←0, pulse frame_error. The counter saturates, so there is one error per idle period.
- Simultaneous events in one cycle:
  - stcp edge and final-bit spi_clk edge: the word completes first and is reported with the old word_cnt; then word_cnt←0 and no error.
  - stcp edge and non-final spi_clk edge: the bit is shifted, then discarded by the stcp rule, and frame_error pulses.
- Multiple faults in one cycle give a single frame_error pulse and increment err_count by 1.

## Timing
- All outputs reset to 0, as do all shifters, counters and synchronizers (async, on rst_n low).
- Input requirement: spi_clk high and low phases ≥ 3 clk periods each. MOSI is stable ≥ 3 clk before and after the spi_clk rise.
- Latency: word_valid asserts 4 clk edges after the clk edge that first samples the final spi_clk high at the pin. The same latency applies from ser_stcp to column_strobe and from ser_stcp to column_index/column_valid update.
- word_data, word_index and column_index hold between pulses.
- Reset mid-word or mid-column: partial state is discarded and the next spi_clk rise is bit 0 of word 0.

## Configuration
- RX_ERROR_COUNT_EN defined: err_count increments once per frame_error pulse and saturates at 16'hFFFF. It clears only on reset.
- Not defined: the counter is not built and err_count is tied to 16'h0000. frame_error still pulses.

## Test plan
- MSB_FIRST=1, channels send 8'hA5/8'h3C/8'hFF → one word_valid with word_data=24'hFF3CA5, word_index=0, 4 clk after the last spi_clk rise.
- Shift pattern 16'h0008 via 16 ser_clk edges, pulse ser_stcp, ser_n_enable=0 → column_strobe pulse, column_index=3, column_valid=1. With 16'h0009 → column_valid=0.
- 24 words then stcp, then 25 words → word_index 0..23 on the first column. The 25th word of the second column is dropped with frame_error=1 and err_count=1.
- 5 bits sent, then idle IDLE_TIMEOUT cycles → frame_error once. The next 8 bits form a clean word with word_index unchanged.
- 3 bits, then ser_stcp → frame_error and word_cnt reset. The next word reports word_index=0.
- rst_n low mid-word (4 bits in) → all outputs 0 immediately. After release, an 8-bit word 8'h81 on all channels reports 24'h818181.
